imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder serving the core's fetch side: accepts a 32-bit fetch address over a valid/ready request channel and, after a fixed programmable latency, returns the 32-bit instruction word over a valid/ready response channel. It sits between the core's fetch logic and a word-organised on-chip instruction store. The store is preloaded through a side write port by the testbench or loader. The block flags misaligned and out-of-range fetches instead of returning data.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words in the store (power of two).
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- LATENCY, 2: cycles from request accept to first response-valid cycle; legal range 1..15.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  fetch byte address.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_inst  out  32  instruction word; 32'h0 when resp_err.
- resp_err  out  1  fetch fault (misaligned or out of range).
- ld_en  in  1  write enable for the preload port.
- ld_addr  in  log2(DEPTH_WORDS)  word index for the preload write.
- ld_data  in  32  preload data.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch req_addr and load cnt=LATENCY-1.
  - If LATENCY==1, go to RESP; else go to WAIT.
- WAIT:
  - req_ready=0.
  - cnt decrements each cycle.
  - When cnt==1, go to RESP.
- Entering RESP: register resp_inst and resp_err from the latched address.
- RESP:
  - resp_valid=1 and req_ready=0.
  - On resp_ready, go to IDLE.
  - While resp_ready=0, resp_inst and resp_err hold stable.
- Fault check on the latched address:
  - Misaligned if addr[1:0]!=0.
  - Out of range if addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH_WORDS.
  - Either fault gives resp_err=1 and resp_inst=32'h0.
- Word index = (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits. Use 33-bit compare arithmetic so no wrap occurs at 32'hFFFF_FFFC.
- Preload port:
  - ld_en writes ld_data to the store at the clock edge, in any state.
  - If a preload write and the RESP-entry read hit the same word on the same edge, the read returns the old data.
- One outstanding request at most; no pipelining of requests.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) puts the block in IDLE:
  - req_ready=1, resp_valid=0, resp_inst=32'h0, resp_err=0, cnt=0.
  - Store contents are not reset.
- Request accepted at edge t: resp_valid=1 from cycle t+LATENCY.
- Response handshake at edge t+LATENCY+k (k≥0): IDLE and req_ready=1 in the following cycle. Peak throughput is one fetch per LATENCY+1 cycles.
- Reset asserted mid-WAIT or mid-RESP: the in-flight fetch is dropped and no response is produced after reset release.
- req_addr is ignored while req_ready=0.

## Structure
- Package imem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - constant ERR_INST=32'h0;
  - the width helper for cnt (4 bits).
- Sub-module imem_array holds the DEPTH_WORDS×32 synchronous-write store:
  - one write port (ld_*);
  - one read port, registered on the RESP-entry enable.
- FSM, counter and fault checks live in imem_responder.

## Test plan
- Basic fetch, LATENCY=2, resp_ready held 1:
  - Stimulus: preload word 0=32'h0000_0413; req 32'h8000_0000 accepted at t.
  - Required: resp_valid at t+2 with resp_inst=32'h0000_0413, resp_err=0; req_ready=1 at t+3.
- Backpressure:
  - Stimulus: preload word 5=32'h00A0_0093; fetch 32'h8000_0014; resp_ready=0 for 4 cycles.
  - Required: resp_valid and the data stay constant throughout; one handshake; req_ready stays 0 until after the handshake.
- Faults:
  - Fetch 32'h8000_0002 gives resp_err=1, resp_inst=0.
  - Fetch 32'h7FFF_FFFC gives resp_err=1, resp_inst=0.
  - Fetch 32'h8000_1000 (DEPTH_WORDS=1024) gives resp_err=1, resp_inst=0.
  - Fetch 32'hFFFF_FFFC gives resp_err=1, resp_inst=0.
- LATENCY=1 and LATENCY=15:
  - Stimulus: back-to-back requests with req_valid held high.
  - Required: accept spacing of LATENCY+1 cycles; resp_valid exactly LATENCY cycles after each accept.
- Same-edge preload collision:
  - Stimulus: word 3=32'h1111_1111; fetch 32'h8000_000C; on the RESP-entry edge, write word 3=32'h2222_2222.
  - Required: response is 32'h1111_1111; the next fetch of the same address returns 32'h2222_2222.
- Reset mid-WAIT (LATENCY=4):
  - Stimulus: assert rst two cycles after accept.
  - Required: outputs go to their reset values immediately; no resp_valid after release; preloaded data is intact on the next fetch.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory responder
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] ERR_INST = 32'h0000_0000;

    localparam int CNT_W = 4;

    // Counter preload: the accept cycle itself counts as the first latency cycle.
    function automatic logic [CNT_W-1:0] cnt_load(input int latency);
        return CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - word-organised instruction store, sync write port and registered read port
module imem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    // Contents survive reset so a preloaded image is kept across core resets.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Same-edge write and read of one word returns the pre-write contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency instruction fetch responder with fault detection
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          LATENCY     = 2,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_inst,
    output logic          resp_err,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data
);

    // 33-bit window bounds so a fetch near 32'hFFFF_FFFC cannot wrap into range.
    localparam logic [32:0] ADDR_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] ADDR_HI = ADDR_LO + 33'(4 * DEPTH_WORDS);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic             resp_err_q;
    logic [31:0]      rd_data;

    logic             accept;
    logic             rd_en;
    logic [31:0]      fetch_addr;
    logic [32:0]      fetch_addr_ext;
    logic             fetch_fault;
    logic [AW-1:0]    fetch_idx;

    assign accept = req_valid && req_ready;

    // With LATENCY==1 the store is read on the accept edge, before addr_q is loaded.
    always_comb begin
        fetch_addr     = (state == IDLE) ? req_addr : addr_q;
        fetch_addr_ext = {1'b0, fetch_addr};
        fetch_fault    = (fetch_addr[1:0] != 2'b00)
                      || (fetch_addr_ext < ADDR_LO)
                      || (fetch_addr_ext >= ADDR_HI);
        fetch_idx      = AW'((fetch_addr - BASE_ADDR) >> 2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE:    req_ready  = 1'b1;
            RESP:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign rd_en = (state_nxt == RESP) && (state != RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            addr_q     <= '0;
            resp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= req_addr;
                cnt    <= cnt_load(LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 1'b1;
            end
            if (rd_en) begin
                resp_err_q <= fetch_fault;
            end
        end
    end

    imem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .rd_en   (rd_en),
        .rd_addr (fetch_idx),
        .rd_data (rd_data)
    );

    assign resp_err  = resp_err_q;
    assign resp_inst = resp_err_q ? ERR_INST : rd_data;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard bench over four responder instances of differing latency
module tb_imem_responder;

    localparam int N = 4;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  resp_valid;
    logic [N-1:0]  resp_ready;
    logic [N-1:0]  resp_err;
    logic [N-1:0]  ld_en;
    logic [31:0]   req_addr  [N];
    logic [31:0]   resp_inst [N];
    logic [31:0]   ld_data   [N];
    logic [9:0]    ld_addr   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        imem_responder #(
            .DEPTH_WORDS (1024),
            .BASE_ADDR   (32'h8000_0000),
            .LATENCY     (g == 0 ? 2 : g == 1 ? 1 : g == 2 ? 15 : 4)
        ) u_dut (
            .clk        (clk),
            .rst        (rst_n),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_addr   (req_addr[g]),
            .resp_valid (resp_valid[g]),
            .resp_ready (resp_ready[g]),
            .resp_inst  (resp_inst[g]),
            .resp_err   (resp_err[g]),
            .ld_en      (ld_en[g]),
            .ld_addr    (ld_addr[g]),
            .ld_data    (ld_data[g])
        );
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   n_acc   = 0;
    int   n_resp  = 0;
    int   n_rise  = 0;
    int   acc_edge = 0;
    int   prev_acc = -1;
    int   cur     = 0;
    bit   busy, post_hs, stab, rv_prev, chk_space;
    logic [31:0] held_inst;
    logic        held_err;
    exp_t sb[$];

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            2:       return 15;
            default: return 4;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut=%h inst=%0d got=%h exp=%h", tag, cur, cur, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the active instance: handshakes, latency, spacing and stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy)    check_eq("rdy_busy", 32'(req_ready[cur]), 32'd0);
            if (post_hs) check_eq("rdy_after_hs", 32'(req_ready[cur]), 32'd1);
            post_hs = 1'b0;
            if (resp_valid[cur]) begin
                if (!rv_prev) begin
                    n_rise++;
                    check_eq("latency", 32'(cyc + 1 - acc_edge), 32'(lat_of(cur)));
                end
                if (stab) begin
                    check_eq("stable_inst", resp_inst[cur], held_inst);
                    check_eq("stable_err", 32'(resp_err[cur]), 32'(held_err));
                end
                held_inst = resp_inst[cur];
                held_err  = resp_err[cur];
                stab      = !resp_ready[cur];
                if (resp_ready[cur]) begin
                    check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check_eq("resp_inst", resp_inst[cur], e.inst);
                        check_eq("resp_err", 32'(resp_err[cur]), 32'(e.err));
                    end
                    n_resp++;
                    busy    = 1'b0;
                    post_hs = 1'b1;
                end
            end else begin
                stab = 1'b0;
            end
            rv_prev = resp_valid[cur];
            if (req_valid[cur] && req_ready[cur]) begin
                if (chk_space && prev_acc >= 0)
                    check_eq("accept_spacing", 32'(cyc + 1 - prev_acc), 32'(lat_of(cur) + 1));
                prev_acc = cyc + 1;
                acc_edge = cyc + 1;
                n_acc++;
                busy = 1'b1;
            end
        end
    end

    task automatic set_cur(input int d);
        @(posedge clk); #1;
        cur = d; rv_prev = 0; stab = 0; busy = 0; post_hs = 0; prev_acc = -1;
    endtask

    task automatic preload(input int d, input int idx, input logic [31:0] data);
        ld_en[d] = 1'b1; ld_addr[d] = 10'(idx); ld_data[d] = data;
        @(posedge clk); #1;
        ld_en[d] = 1'b0;
    endtask

    task automatic wait_acc(input int target, input int budget);
        for (int k = 0; k < budget && n_acc < target; k++) begin
            @(posedge clk); #1;
        end
        check_eq("accept_seen", 32'(n_acc >= target), 32'd1);
    endtask

    task automatic wait_resp(input int target, input int budget);
        for (int k = 0; k < budget && n_resp < target; k++) begin
            @(posedge clk); #1;
        end
        check_eq("resp_seen", 32'(n_resp >= target), 32'd1);
    endtask

    task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] ei, input logic ee,
                         input int bp, input int cidx, input logic [31:0] cdata);
        int base_acc, base_resp;
        base_acc  = n_acc;
        base_resp = n_resp;
        sb.push_back('{inst: ei, err: ee});
        resp_ready[d] = (bp == 0);
        req_valid[d]  = 1'b1;
        req_addr[d]   = a;
        wait_acc(base_acc + 1, 50);
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom;
        if (cidx >= 0) begin
            ld_en[d] = 1'b1; ld_addr[d] = 10'(cidx); ld_data[d] = cdata;
            @(posedge clk); #1;
            ld_en[d] = 1'b0;
        end
        if (bp > 0) begin
            for (int k = 0; k < 50 && !resp_valid[d]; k++) begin
                @(posedge clk); #1;
            end
            repeat (bp) begin
                @(posedge clk); #1;
            end
            resp_ready[d] = 1'b1;
        end
        wait_resp(base_resp + 1, 50);
        resp_ready[d] = 1'b1;
    endtask

    task automatic back_to_back(input int d, input logic [31:0] a, input logic [31:0] ei, input int n);
        int base_acc, base_resp;
        base_acc  = n_acc;
        base_resp = n_resp;
        for (int i = 0; i < n; i++) sb.push_back('{inst: ei, err: 1'b0});
        chk_space     = 1'b1;
        resp_ready[d] = 1'b1;
        req_valid[d]  = 1'b1;
        req_addr[d]   = a;
        wait_acc(base_acc + n, 200);
        req_valid[d] = 1'b0;
        wait_resp(base_resp + n, 100);
        chk_space = 1'b0;
    endtask

    initial begin
        int base_resp, base_rise, base_acc;
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '1;
        ld_en      = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i] = '0; ld_data[i] = '0; ld_addr[i] = '0;
        end
        #2;
        for (int i = 0; i < N; i++) begin
            cur = i;
            check_eq("rst_req_ready", 32'(req_ready[i]), 32'd1);
            check_eq("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
            check_eq("rst_resp_inst", resp_inst[i], 32'h0);
            check_eq("rst_resp_err", 32'(resp_err[i]), 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        set_cur(0);
        preload(0, 0,    32'h0000_0413);
        preload(0, 5,    32'h00A0_0093);
        preload(0, 3,    32'h1111_1111);
        preload(0, 1023, 32'h0FF0_0FF3);
        fetch(0, 32'h8000_0000, 32'h0000_0413, 1'b0, 0, -1, '0);
        base_resp = n_resp;
        fetch(0, 32'h8000_0014, 32'h00A0_0093, 1'b0, 4, -1, '0);
        check_eq("bp_one_handshake", 32'(n_resp - base_resp), 32'd1);
        fetch(0, 32'h8000_0002, 32'h0, 1'b1, 0, -1, '0);
        fetch(0, 32'h7FFF_FFFC, 32'h0, 1'b1, 0, -1, '0);
        fetch(0, 32'h8000_1000, 32'h0, 1'b1, 0, -1, '0);
        fetch(0, 32'hFFFF_FFFC, 32'h0, 1'b1, 0, -1, '0);
        fetch(0, 32'h8000_0FFC, 32'h0FF0_0FF3, 1'b0, 0, -1, '0);
        fetch(0, 32'h8000_000C, 32'h1111_1111, 1'b0, 0, 3, 32'h2222_2222);
        fetch(0, 32'h8000_000C, 32'h2222_2222, 1'b0, 0, -1, '0);

        set_cur(1);
        preload(1, 1, 32'h0010_0113);
        back_to_back(1, 32'h8000_0004, 32'h0010_0113, 4);

        set_cur(2);
        preload(2, 1, 32'h0020_0193);
        back_to_back(2, 32'h8000_0004, 32'h0020_0193, 3);

        set_cur(3);
        preload(3, 7, 32'h0070_0393);
        base_acc  = n_acc;
        base_rise = n_rise;
        req_valid[3] = 1'b1;
        req_addr[3]  = 32'h8000_001C;
        wait_acc(base_acc + 1, 50);
        req_valid[3] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        busy = 0; post_hs = 0; rv_prev = 0; stab = 0;
        check_eq("midrst_req_ready", 32'(req_ready[3]), 32'd1);
        check_eq("midrst_resp_valid", 32'(resp_valid[3]), 32'd0);
        check_eq("midrst_resp_inst", resp_inst[3], 32'h0);
        check_eq("midrst_resp_err", 32'(resp_err[3]), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_eq("no_resp_after_rst", 32'(n_rise - base_rise), 32'd0);
        check_eq("sb_empty_after_rst", 32'(sb.size()), 32'd0);
        fetch(3, 32'h8000_001C, 32'h0070_0393, 1'b0, 0, -1, '0);

        repeat (3) @(posedge clk);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
